// File: rtl/ysyx_25040109_lsu_if.sv
// Data-memory bus between the LSU (master) and the dmem slave (slave).
// AXI-lite style channels:
//   AR : araddr, arvalid (M->S), arready (S->M)
//   R  : rdata, rresp, rvalid (S->M), rready (M->S)
//   AW : awaddr, awvalid (M->S), awready (S->M)
//   W  : wdata, wstrb, wen, wvalid (M->S), wready (S->M)
//   B  : bresp, bvalid (S->M), bready (M->S)
interface ysyx_25040109_lsu_if #(
  parameter int XLEN = 32
);
  logic [XLEN-1:0]   araddr;
  logic              arvalid;
  logic              arready;
  logic [XLEN-1:0]   rdata;
  logic [1:0]        rresp;
  logic              rvalid;
  logic              rready;
  logic [XLEN-1:0]   awaddr;
  logic              awvalid;
  logic              awready;
  logic [XLEN-1:0]   wdata;
  logic [XLEN/8-1:0] wstrb;
  logic              wen;
  logic              wvalid;
  logic              wready;
  logic [1:0]        bresp;
  logic              bvalid;
  logic              bready;

  modport master (
    output araddr, arvalid, input arready,
    input  rdata, rresp, rvalid, output rready,
    output awaddr, awvalid, input awready,
    output wdata, wstrb, wen, wvalid, input wready,
    input  bresp, bvalid, output bready
  );

  modport slave (
    input  araddr, arvalid, output arready,
    output rdata, rresp, rvalid, input rready,
    input  awaddr, awvalid, output awready,
    input  wdata, wstrb, wen, wvalid, output wready,
    output bresp, bvalid, input bready
  );
endinterface

// File: rtl/ysyx_25040109_lsu.sv
// Load/store unit: takes one load/store from execute, runs it on the dmem
// AR/R or AW/W/B channels, returns one response (data + error). One access
// in flight at a time.
// Ports:
//   clk, rst            clock, async active-low reset
//   req_*               execute-stage request (valid/ready, wen, addr,
//                       wdata, size 0/1/2 = B/H/W, unsigned)
//   rsp_*               response (valid/ready, rdata, err)
//   dmem                master side of the dmem bus interface
// Optional feature macro: LSU_MISALIGN_CHECK_EN -- when defined, misaligned
// halfword/word accesses and size 3 skip the bus and respond with err=1.
module ysyx_25040109_lsu #(
  parameter int         XLEN        = 32,
  parameter logic [1:0] RESP_SLVERR = 2'b10
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic            req_wen,
  input  logic [XLEN-1:0] req_addr,
  input  logic [XLEN-1:0] req_wdata,
  input  logic [1:0]      req_size,
  input  logic            req_unsigned,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic [XLEN-1:0] rsp_rdata,
  output logic            rsp_err,
  ysyx_25040109_lsu_if.master dmem
);

  typedef enum logic [2:0] {S_IDLE, S_AR, S_R, S_WR, S_B, S_RSP} state_e;

  state_e          r_state, w_nstate;
  logic [XLEN-1:0] r_addr, r_wdata, r_rdata;
  logic [1:0]      r_size;
  logic            r_unsigned, r_store, r_err, r_aw_done, r_w_done;

  logic            w_misalign, w_aw_hs, w_w_hs, w_rerr, w_berr;
  logic [XLEN-1:0] w_shifted, w_lane;

`ifdef LSU_MISALIGN_CHECK_EN
  assign w_misalign = (req_size == 2'd1 && req_addr[0]) ||
                      (req_size == 2'd2 && req_addr[1:0] != 2'b00) ||
                      (req_size == 2'd3);
`else
  assign w_misalign = 1'b0;
`endif

  // SLVERR is the expected error code; any other nonzero code also counts.
  assign w_rerr = (dmem.rresp == RESP_SLVERR) || (dmem.rresp != 2'b00);
  assign w_berr = (dmem.bresp == RESP_SLVERR) || (dmem.bresp != 2'b00);

  assign w_aw_hs = dmem.awvalid & dmem.awready;
  assign w_w_hs  = dmem.wvalid  & dmem.wready;

  // Logical shift: an unaligned half at offset 3 zero-fills above bit 31
  // rather than wrapping around the word.
  assign w_shifted = dmem.rdata >> {r_addr[1:0], 3'b000};

  always_comb begin
    case (r_size)
      2'd0:    w_lane = {{(XLEN-8){w_shifted[7] & ~r_unsigned}},  w_shifted[7:0]};
      2'd1:    w_lane = {{(XLEN-16){w_shifted[15] & ~r_unsigned}}, w_shifted[15:0]};
      default: w_lane = dmem.rdata;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_nstate;
  end

  // Next state
  always_comb begin
    w_nstate = r_state;
    case (r_state)
      S_IDLE: if (req_valid) w_nstate = w_misalign ? S_RSP : (req_wen ? S_WR : S_AR);
      S_AR:   if (dmem.arready) w_nstate = S_R;
      S_R:    if (dmem.rvalid)  w_nstate = S_RSP;
      // Either channel may have finished earlier or finish this cycle.
      S_WR:   if ((r_aw_done | w_aw_hs) && (r_w_done | w_w_hs)) w_nstate = S_B;
      S_B:    if (dmem.bvalid)  w_nstate = S_RSP;
      S_RSP:  if (rsp_ready)    w_nstate = S_IDLE;
      default: w_nstate = S_IDLE;
    endcase
  end

  // Outputs
  always_comb begin
    req_ready    = (r_state == S_IDLE);
    dmem.arvalid = (r_state == S_AR);
    dmem.rready  = (r_state == S_R);
    dmem.awvalid = (r_state == S_WR) && !r_aw_done;
    dmem.wvalid  = (r_state == S_WR) && !r_w_done;
    dmem.wen     = (r_state == S_WR);
    dmem.bready  = (r_state == S_B);
    rsp_valid    = (r_state == S_RSP);
    dmem.wstrb   = '0;
    if (r_state == S_WR) begin
      case (r_size)
        2'd0:    dmem.wstrb = 4'b0001;
        2'd1:    dmem.wstrb = 4'b0011;
        default: dmem.wstrb = 4'b1111;
      endcase
    end
  end

  assign dmem.araddr = {r_addr[XLEN-1:2], 2'b00};
  assign dmem.awaddr = r_addr;
  assign dmem.wdata  = r_wdata;
  assign rsp_rdata   = r_rdata;
  assign rsp_err     = r_err;

  // Request latch and response capture
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_addr     <= '0;
      r_wdata    <= '0;
      r_size     <= '0;
      r_unsigned <= 1'b0;
      r_store    <= 1'b0;
      r_rdata    <= '0;
      r_err      <= 1'b0;
      r_aw_done  <= 1'b0;
      r_w_done   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: if (req_valid) begin
          r_addr     <= req_addr;
          r_wdata    <= req_wdata;
          r_size     <= req_size;
          r_unsigned <= req_unsigned;
          r_store    <= req_wen;
          r_rdata    <= '0;
          r_err      <= w_misalign;
          r_aw_done  <= 1'b0;
          r_w_done   <= 1'b0;
        end
        S_R: if (dmem.rvalid) begin
          r_rdata <= w_lane;
          r_err   <= w_rerr;
        end
        S_WR: begin
          if (w_aw_hs) r_aw_done <= 1'b1;
          if (w_w_hs)  r_w_done  <= 1'b1;
        end
        S_B: if (dmem.bvalid) begin
          r_rdata <= '0;
          r_err   <= w_berr;
        end
        default: ;
      endcase
    end
  end

  // r_store mirrors the accepted request type; kept for debug visibility.
  logic w_unused;
  assign w_unused = r_store;

endmodule

// File: tb/tb_ysyx_25040109_lsu.sv
module tb_ysyx_25040109_lsu;
  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_wen, req_unsigned;
  logic [31:0] req_addr, req_wdata;
  logic [1:0]  req_size;
  logic        rsp_valid, rsp_ready, rsp_err;
  logic [31:0] rsp_rdata;
  int          n_cmp = 0;
  int          n_err = 0;

  always #5 clk = ~clk;

  ysyx_25040109_lsu_if #(.XLEN(32)) bus();

  ysyx_25040109_lsu #(.XLEN(32), .RESP_SLVERR(2'b10)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_wen(req_wen),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_size(req_size),
    .req_unsigned(req_unsigned),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err),
    .dmem(bus)
  );

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference: pick the lane by byte offset, mask, and sign-extend numerically.
  function automatic logic [31:0] ref_load(input logic [31:0] mem, input logic [1:0] off,
                                           input logic [1:0] sz, input logic uns);
    longint v;
    int     bits;
    bits = (sz == 2'd0) ? 8 : (sz == 2'd1) ? 16 : 32;
    if (bits == 32) return mem;
    v = (longint'(mem) >> (8 * int'(off))) & ((longint'(1) << bits) - 1);
    if (!uns && v >= (longint'(1) << (bits - 1))) v = v - (longint'(1) << bits);
    return v[31:0];
  endfunction

  function automatic logic [3:0] ref_strb(input logic [1:0] sz);
    return (sz == 2'd0) ? 4'h1 : (sz == 2'd1) ? 4'h3 : 4'hF;
  endfunction

  function automatic bit ref_mis(input logic [31:0] a, input logic [1:0] sz);
`ifdef LSU_MISALIGN_CHECK_EN
    return (sz == 2'd1 && a[0]) || (sz == 2'd2 && a[1:0] != 2'b00) || sz == 2'd3;
`else
    return 1'b0;
`endif
  endfunction

  task automatic issue(input logic wen_i, input logic [31:0] a, input logic [31:0] wd,
                       input logic [1:0] sz, input logic uns);
    chk("req_ready_idle", req_ready, 1);
    req_valid = 1'b1; req_wen = wen_i; req_addr = a; req_wdata = wd;
    req_size = sz; req_unsigned = uns;
    tick();
    // Scramble request fields: the DUT must use its latched copy.
    req_valid = 1'b0; req_wen = 1'($urandom); req_addr = $urandom; req_wdata = $urandom;
    req_size = 2'($urandom); req_unsigned = 1'($urandom);
    chk("req_ready_busy", req_ready, 0);
  endtask

  task automatic get_rsp(input logic [31:0] d, input logic e, input int hold);
    for (int k = 0; k < hold; k++) begin
      chk("rsp_valid_hold", rsp_valid, 1);
      chk("rsp_rdata_hold", rsp_rdata, d);
      chk("rsp_err_hold", rsp_err, e);
      chk("req_ready_hold", req_ready, 0);
      tick();
    end
    chk("rsp_valid", rsp_valid, 1);
    chk("rsp_rdata", rsp_rdata, d);
    chk("rsp_err", rsp_err, e);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    chk("rsp_valid_drop", rsp_valid, 0);
    chk("req_ready_back", req_ready, 1);
  endtask

  task automatic do_load(input logic [31:0] a, input logic [1:0] sz, input logic uns,
                         input logic [31:0] mem, input logic [1:0] resp,
                         input int arw, input int hold);
    issue(1'b0, a, 32'h0, sz, uns);
    if (ref_mis(a, sz)) begin
      chk("mis_arvalid", bus.arvalid, 0);
      get_rsp(32'h0, 1'b1, hold);
      return;
    end
    for (int k = 0; k < arw; k++) begin
      chk("arvalid_wait", bus.arvalid, 1);
      chk("araddr_wait", bus.araddr, {a[31:2], 2'b00});
      tick();
    end
    chk("arvalid", bus.arvalid, 1);
    chk("araddr", bus.araddr, {a[31:2], 2'b00});
    bus.arready = 1'b1;
    tick();
    bus.arready = 1'b0;
    chk("arvalid_drop", bus.arvalid, 0);
    chk("rready", bus.rready, 1);
    chk("rsp_valid_in_r", rsp_valid, 0);
    bus.rvalid = 1'b1; bus.rdata = mem; bus.rresp = resp;
    tick();
    bus.rvalid = 1'b0; bus.rdata = $urandom; bus.rresp = 2'($urandom);
    chk("rready_drop", bus.rready, 0);
    get_rsp(ref_load(mem, a[1:0], sz, uns), resp != 2'b00, hold);
  endtask

  task automatic do_store(input logic [31:0] a, input logic [1:0] sz, input logic [31:0] wd,
                          input logic [1:0] resp, input int aww, input int wwt, input int hold);
    int aw_n, w_n;
    issue(1'b1, a, wd, sz, 1'b0);
    if (ref_mis(a, sz)) begin
      chk("mis_awvalid", bus.awvalid, 0);
      chk("mis_wvalid", bus.wvalid, 0);
      get_rsp(32'h0, 1'b1, hold);
      return;
    end
    aw_n = 0; w_n = 0;
    for (int c = 0; c < 20 && !(aw_n > 0 && w_n > 0); c++) begin
      chk("awvalid", bus.awvalid, aw_n == 0);
      chk("wvalid", bus.wvalid, w_n == 0);
      if (aw_n == 0) chk("awaddr", bus.awaddr, a);
      if (w_n == 0) begin
        chk("wdata", bus.wdata, wd);
        chk("wstrb", bus.wstrb, ref_strb(sz));
        chk("wen", bus.wen, 1);
      end
      bus.awready = (c >= aww);
      bus.wready  = (c >= wwt);
      if (bus.awvalid && bus.awready) aw_n++;
      if (bus.wvalid && bus.wready) w_n++;
      tick();
    end
    bus.awready = 1'b0; bus.wready = 1'b0;
    chk("aw_count", aw_n, 1);
    chk("w_count", w_n, 1);
    chk("awvalid_done", bus.awvalid, 0);
    chk("wvalid_done", bus.wvalid, 0);
    chk("bready", bus.bready, 1);
    chk("rsp_valid_in_b", rsp_valid, 0);
    bus.bvalid = 1'b1; bus.bresp = resp;
    tick();
    bus.bvalid = 1'b0; bus.bresp = 2'($urandom);
    chk("bready_drop", bus.bready, 0);
    get_rsp(32'h0, resp != 2'b00, hold);
  endtask

  initial begin
    logic [31:0] a, m;
    logic [1:0]  sz, rs;
    rst = 1'b0;
    req_valid = 0; req_wen = 0; req_addr = 0; req_wdata = 0; req_size = 0; req_unsigned = 0;
    rsp_ready = 0;
    bus.arready = 0; bus.rdata = 0; bus.rresp = 0; bus.rvalid = 0;
    bus.awready = 0; bus.wready = 0; bus.bresp = 0; bus.bvalid = 0;
    tick();
    chk("rst_req_ready", req_ready, 1);
    chk("rst_arvalid", bus.arvalid, 0);
    chk("rst_rready", bus.rready, 0);
    chk("rst_awvalid", bus.awvalid, 0);
    chk("rst_wvalid", bus.wvalid, 0);
    chk("rst_bready", bus.bready, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_rdata", rsp_rdata, 0);
    chk("rst_rsp_err", rsp_err, 0);
    chk("rst_araddr", bus.araddr, 0);
    chk("rst_wstrb", bus.wstrb, 0);
    tick();
    rst = 1'b1;
    tick();

    // Directed cases
    do_load(32'h8000_0003, 2'd0, 1'b0, 32'h80FF_7F01, 2'b00, 0, 0);
    chk("sbyte_model", ref_load(32'h80FF_7F01, 2'd3, 2'd0, 1'b0), 32'hFFFF_FF80);
    do_load(32'h8000_0002, 2'd1, 1'b1, 32'h80FF_7F01, 2'b00, 0, 0);
    do_load(32'h8000_0002, 2'd1, 1'b0, 32'h80FF_7F01, 2'b00, 2, 0);
    do_store(32'h8000_0006, 2'd1, 32'h1234_ABCD, 2'b00, 3, 0, 0);
    do_load(32'h8000_0010, 2'd2, 1'b0, 32'hDEAD_BEEF, 2'b10, 0, 0);
    do_store(32'h8000_0020, 2'd2, 32'hCAFE_F00D, 2'b10, 0, 2, 0);
    do_store(32'h8000_0021, 2'd0, 32'h0000_00A5, 2'b00, 1, 1, 0);
    do_load(32'h8000_0001, 2'd2, 1'b0, 32'h1122_3344, 2'b00, 0, 0);
    do_load(32'h8000_0003, 2'd1, 1'b0, 32'hFF00_0000, 2'b00, 0, 0);
    do_load(32'h8000_0008, 2'd0, 1'b0, 32'h0000_00C3, 2'b00, 0, 5);

    // Reset while in R: outputs clear without waiting for a clock edge
    issue(1'b0, 32'h8000_0040, 32'h0, 2'd2, 1'b0);
    bus.arready = 1'b1;
    tick();
    bus.arready = 1'b0;
    chk("pre_rst_rready", bus.rready, 1);
    #2 rst = 1'b0;
    #1;
    chk("arst_req_ready", req_ready, 1);
    chk("arst_rready", bus.rready, 0);
    chk("arst_rsp_valid", rsp_valid, 0);
    bus.rvalid = 1'b1; bus.rdata = 32'h5A5A_5A5A;
    tick();
    rst = 1'b1;
    tick();
    chk("post_rst_rsp_valid", rsp_valid, 0);
    chk("post_rst_req_ready", req_ready, 1);
    chk("post_rst_rsp_rdata", rsp_rdata, 0);
    bus.rvalid = 1'b0;
    tick();

    // Randomized traffic against the reference
    for (int i = 0; i < 40; i++) begin
      a  = 32'h8000_0000 | ($urandom & 32'h0000_0FFF);
      sz = 2'($urandom_range(0, 3));
      m  = $urandom;
      rs = ($urandom_range(0, 3) == 0) ? 2'b10 : (($urandom_range(0, 7) == 0) ? 2'b01 : 2'b00);
      if ($urandom_range(0, 1) == 1)
        do_store(a, sz, m, rs, $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 2));
      else
        do_load(a, sz, 1'($urandom), m, rs, $urandom_range(0, 3), $urandom_range(0, 2));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
